// File: rtl/rvvitxarb.sv
// rvvitxarb: frame-atomic round-robin arbiter for the tracer MAC TX stream.
// Two AXI-stream sources share one MAC port a whole frame at a time.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   S0T*/S1T*             - source streams (0 = RVVI packetizer, 1 = ctrl/status)
//   MT*                   - stream to the MAC TX FIFO
//   InterPacketDelay      - idle cycles inserted after each frame
//   Grant, Busy           - owner of the port, high while a frame is in flight
//   FramesSent0/1         - completed frame counters (wrapping)
//   Overlong              - sticky flag: a frame exceeded MAX_FRAME_BEATS
module rvvitxarb #(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_FRAME_BEATS = 512,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] S0Tdata,
    input  logic [KEEP_WIDTH-1:0] S0Tkeep,
    input  logic                  S0Tvalid,
    input  logic                  S0Tlast,
    output logic                  S0Tready,
    input  logic [DATA_WIDTH-1:0] S1Tdata,
    input  logic [KEEP_WIDTH-1:0] S1Tkeep,
    input  logic                  S1Tvalid,
    input  logic                  S1Tlast,
    output logic                  S1Tready,
    output logic [DATA_WIDTH-1:0] MTdata,
    output logic [KEEP_WIDTH-1:0] MTkeep,
    output logic                  MTvalid,
    output logic                  MTlast,
    input  logic                  MTready,
    input  logic [31:0]           InterPacketDelay,
    output logic                  Grant,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  FramesSent0,
    output logic [CNT_WIDTH-1:0]  FramesSent1,
    output logic                  Overlong
);

    localparam int BW = $clog2(MAX_FRAME_BEATS) + 1;
    localparam logic [BW-1:0] MAX_BEATS = BW'(MAX_FRAME_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic                 grantQ;
    logic                 grantNext;
    logic                 lastGrant;
    logic [BW-1:0]        beatCnt;
    logic [31:0]          gapCnt;
    logic [CNT_WIDTH-1:0] framesSent0Q;
    logic [CNT_WIDTH-1:0] framesSent1Q;
    logic                 overlongQ;
    logic                 handshake;

    assign Grant       = grantQ;
    assign Busy        = (state == SEND);
    assign FramesSent0 = framesSent0Q;
    assign FramesSent1 = framesSent1Q;
    assign Overlong    = overlongQ;
    assign handshake   = MTvalid & MTready;

    always_comb begin
        stateNext = state;
        grantNext = grantQ;
        MTdata    = '0;
        MTkeep    = '0;
        MTvalid   = 1'b0;
        MTlast    = 1'b0;
        S0Tready  = 1'b0;
        S1Tready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (S0Tvalid || S1Tvalid) begin
                    stateNext = SEND;
                    // On a tie the source that did not own the last frame wins.
                    if (S0Tvalid && S1Tvalid) grantNext = ~lastGrant;
                    else                      grantNext = S1Tvalid;
                end
            end
            SEND: begin
                if (grantQ) begin
                    MTdata   = S1Tdata;
                    MTkeep   = S1Tkeep;
                    MTvalid  = S1Tvalid;
                    MTlast   = S1Tlast;
                    S1Tready = MTready;
                end else begin
                    MTdata   = S0Tdata;
                    MTkeep   = S0Tkeep;
                    MTvalid  = S0Tvalid;
                    MTlast   = S0Tlast;
                    S0Tready = MTready;
                end
                if (MTvalid && MTready && MTlast) begin
                    stateNext = (InterPacketDelay != 32'd0) ? GAP : IDLE;
                end
            end
            GAP: begin
                // <= 1 rather than == 1 so a zero count can never wedge the FSM.
                if (gapCnt <= 32'd1) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grantQ       <= 1'b0;
            lastGrant    <= 1'b1;
            beatCnt      <= '0;
            gapCnt       <= '0;
            framesSent0Q <= '0;
            framesSent1Q <= '0;
            overlongQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            grantQ <= grantNext;
            if (state == IDLE && stateNext == SEND) begin
                lastGrant <= grantNext;
            end
            if (state == GAP) begin
                gapCnt <= gapCnt - 32'd1;
            end
            if (handshake) begin
                if (beatCnt == MAX_BEATS) overlongQ <= 1'b1;
                if (MTlast) begin
                    beatCnt <= '0;
                    gapCnt  <= InterPacketDelay;
                    if (grantQ) framesSent1Q <= framesSent1Q + CNT_WIDTH'(1);
                    else        framesSent0Q <= framesSent0Q + CNT_WIDTH'(1);
                end else if (beatCnt != '1) begin
                    beatCnt <= beatCnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rvvitxarb.sv
// tb_rvvitxarb: scoreboard bench for the rvvitxarb MAC TX arbiter.
// Sources are queue-driven; every accepted M beat is checked against its source's expected queue.
module tb_rvvitxarb;

    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int MAXB = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] S0Tdata = '0;
    logic [KW-1:0] S0Tkeep = '0;
    logic          S0Tvalid = 1'b0;
    logic          S0Tlast = 1'b0;
    logic          S0Tready;
    logic [DW-1:0] S1Tdata = '0;
    logic [KW-1:0] S1Tkeep = '0;
    logic          S1Tvalid = 1'b0;
    logic          S1Tlast = 1'b0;
    logic          S1Tready;
    logic [DW-1:0] MTdata;
    logic [KW-1:0] MTkeep;
    logic          MTvalid;
    logic          MTlast;
    logic          MTready = 1'b1;
    logic [31:0]   InterPacketDelay = '0;
    logic          Grant;
    logic          Busy;
    logic [CW-1:0] FramesSent0;
    logic [CW-1:0] FramesSent1;
    logic          Overlong;

    rvvitxarb #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .MAX_FRAME_BEATS(MAXB),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .S0Tdata(S0Tdata),
        .S0Tkeep(S0Tkeep),
        .S0Tvalid(S0Tvalid),
        .S0Tlast(S0Tlast),
        .S0Tready(S0Tready),
        .S1Tdata(S1Tdata),
        .S1Tkeep(S1Tkeep),
        .S1Tvalid(S1Tvalid),
        .S1Tlast(S1Tlast),
        .S1Tready(S1Tready),
        .MTdata(MTdata),
        .MTkeep(MTkeep),
        .MTvalid(MTvalid),
        .MTlast(MTlast),
        .MTready(MTready),
        .InterPacketDelay(InterPacketDelay),
        .Grant(Grant),
        .Busy(Busy),
        .FramesSent0(FramesSent0),
        .FramesSent1(FramesSent1),
        .Overlong(Overlong)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int src;
        int cyc;
    } start_t;

    beat_t  q0[$];
    beat_t  q1[$];
    beat_t  exp0[$];
    beat_t  exp1[$];
    start_t startLog[$];
    bit     busyLog[int];
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     beatsSeen = 0;
    bit     pop0 = 0;
    bit     pop1 = 0;
    bit     inFrame = 0;
    bit     toggleReady = 0;
    int     curSrc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source drivers and M-side monitor: inputs change on the falling edge,
    // outputs are observed 1 time unit later, well clear of the rising edge.
    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        logic  expR0;
        logic  expR1;
        if (pop0 && q0.size() > 0) void'(q0.pop_front());
        if (pop1 && q1.size() > 0) void'(q1.pop_front());
        MTready = toggleReady ? ~MTready : 1'b1;
        S0Tvalid = (q0.size() > 0);
        if (S0Tvalid) {S0Tdata, S0Tkeep, S0Tlast} = q0[0];
        else          {S0Tdata, S0Tkeep, S0Tlast} = '0;
        S1Tvalid = (q1.size() > 0);
        if (S1Tvalid) {S1Tdata, S1Tkeep, S1Tlast} = q1[0];
        else          {S1Tdata, S1Tkeep, S1Tlast} = '0;
        #1;
        pop0 = S0Tvalid && S0Tready;
        pop1 = S1Tvalid && S1Tready;
        if (reset) begin
            inFrame   = 0;
            beatsSeen = 0;
        end else begin
            busyLog[cyc] = Busy;
            expR0 = Busy && !Grant && MTready;
            expR1 = Busy && Grant && MTready;
            checks++;
            if ({S0Tready, S1Tready, MTvalid && !Busy} !== {expR0, expR1, 1'b0}) begin
                errors++;
                $display("FAIL ready cyc=%0d got r0=%b r1=%b mv=%b expected r0=%b r1=%b",
                         cyc, S0Tready, S1Tready, MTvalid, expR0, expR1);
            end
            if (MTvalid && MTready) begin
                beatsSeen++;
                got = {MTdata, MTkeep, MTlast};
                checks++;
                if (Grant ? exp1.size() == 0 : exp0.size() == 0) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got %h from src %0d expected no beat",
                             cyc, got, Grant);
                end else begin
                    e = Grant ? exp1.pop_front() : exp0.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat cyc=%0d got %h expected %h", cyc, got, e);
                    end
                end
                checks++;
                if (inFrame && int'(Grant) != curSrc) begin
                    errors++;
                    $display("FAIL interleave cyc=%0d got src %0d expected src %0d",
                             cyc, Grant, curSrc);
                end
                if (!inFrame) startLog.push_back('{int'(Grant), cyc});
                curSrc  = int'(Grant);
                inFrame = !MTlast;
            end
        end
    end

    task automatic pushFrame(input int src, input int n, input int id);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {4'(src), 12'(id), 16'(i)};
            b.keep = 4'((src * 7 + i + id) % 16);
            b.last = (i == n - 1);
            if (src == 1) begin
                q1.push_back(b);
                exp1.push_back(b);
            end else begin
                q0.push_back(b);
                exp0.push_back(b);
            end
        end
    endtask

    task automatic clearAll();
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
        startLog.delete();
        pop0 = 0;
        pop1 = 0;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        toggleReady = 0;
        clearAll();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic waitBeats(input int n, output bit ok);
        int i = 0;
        while (beatsSeen < n && i < 500) begin
            @(posedge clk);
            #2;
            i++;
        end
        ok = (beatsSeen >= n);
    endtask

    task automatic waitDone(output bit ok);
        int i = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || Busy) && i < 2000) begin
            @(posedge clk);
            #2;
            i++;
        end
        ok = (exp0.size() == 0 && exp1.size() == 0 && !Busy);
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if ({Busy, Grant, Overlong, FramesSent0, FramesSent1} !== '0) begin
            errors++;
            $display("FAIL reset_regs got busy=%b grant=%b ovl=%b fs0=%0d fs1=%0d expected all 0",
                     Busy, Grant, Overlong, FramesSent0, FramesSent1);
        end
        @(negedge clk);
        #2;
        checks++;
        if ({MTvalid, MTlast, S0Tready, S1Tready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs got mv=%b ml=%b r0=%b r1=%b expected 0000",
                     MTvalid, MTlast, S0Tready, S1Tready);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int c0;
        applyReset();
        InterPacketDelay = 32'd3;
        c0 = cyc;
        pushFrame(0, 4, 1);
        pushFrame(1, 2, 2);
        waitBeats(4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout got %0d beats expected 4", beatsSeen);
        end
        // Reprogramming during the gap must not shorten it.
        InterPacketDelay = 32'd0;
        waitDone(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done_timeout got busy=%b expected idle", Busy);
        end
        checks++;
        if (FramesSent0 !== 4'd1 || FramesSent1 !== 4'd1) begin
            errors++;
            $display("FAIL single_count got fs0=%0d fs1=%0d expected 1 1",
                     FramesSent0, FramesSent1);
        end
        checks++;
        if (startLog.size() != 2) begin
            errors++;
            $display("FAIL single_starts got %0d frames expected 2", startLog.size());
        end else begin
            checks++;
            if (startLog[0].src != 0 || startLog[0].cyc != c0 + 1) begin
                errors++;
                $display("FAIL single_first got src %0d at +%0d expected src 0 at +1",
                         startLog[0].src, startLog[0].cyc - c0);
            end
            checks++;
            if (startLog[1].src != 1 || startLog[1].cyc != c0 + 9) begin
                errors++;
                $display("FAIL single_second got src %0d at +%0d expected src 1 at +9",
                         startLog[1].src, startLog[1].cyc - c0);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (!busyLog.exists(c0 + k) || busyLog[c0 + k] != (k <= 4)) begin
                errors++;
                $display("FAIL single_busy at +%0d got %b expected %b",
                         k, busyLog.exists(c0 + k) ? busyLog[c0 + k] : 1'bx, k <= 4);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        applyReset();
        InterPacketDelay = 32'd0;
        for (int f = 0; f < 4; f++) begin
            pushFrame(0, 2, 10 + f);
            pushFrame(1, 2, 20 + f);
        end
        waitDone(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout got busy=%b expected idle", Busy);
        end
        checks++;
        if (FramesSent0 !== 4'd4 || FramesSent1 !== 4'd4) begin
            errors++;
            $display("FAIL rr_count got fs0=%0d fs1=%0d expected 4 4",
                     FramesSent0, FramesSent1);
        end
        checks++;
        if (startLog.size() != 8) begin
            errors++;
            $display("FAIL rr_frames got %0d expected 8", startLog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (startLog[i].src != i % 2) begin
                    errors++;
                    $display("FAIL rr_order frame %0d got src %0d expected %0d",
                             i, startLog[i].src, i % 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        applyReset();
        InterPacketDelay = 32'd1;
        toggleReady = 1;
        pushFrame(1, 3, 30);
        waitDone(ok);
        toggleReady = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout got busy=%b expected idle", Busy);
        end
        checks++;
        if (FramesSent1 !== 4'd1 || FramesSent0 !== 4'd0) begin
            errors++;
            $display("FAIL bp_count got fs0=%0d fs1=%0d expected 0 1",
                     FramesSent0, FramesSent1);
        end
    endtask

    task automatic test_overlong();
        bit ok;
        applyReset();
        InterPacketDelay = 32'd2;
        pushFrame(0, 10, 40);
        waitBeats(8, ok);
        checks++;
        if (!ok || Overlong !== 1'b0) begin
            errors++;
            $display("FAIL ovl_at8 got ok=%b ovl=%b expected ok=1 ovl=0", ok, Overlong);
        end
        waitBeats(9, ok);
        checks++;
        if (!ok || Overlong !== 1'b1) begin
            errors++;
            $display("FAIL ovl_at9 got ok=%b ovl=%b expected ok=1 ovl=1", ok, Overlong);
        end
        waitDone(ok);
        checks++;
        if (!ok || FramesSent0 !== 4'd1 || beatsSeen != 10) begin
            errors++;
            $display("FAIL ovl_frame got ok=%b fs0=%0d beats=%0d expected 1 1 10",
                     ok, FramesSent0, beatsSeen);
        end
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (Overlong !== 1'b1) begin
            errors++;
            $display("FAIL ovl_sticky got %b expected 1", Overlong);
        end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        applyReset();
        checks++;
        if (Overlong !== 1'b0) begin
            errors++;
            $display("FAIL ovl_reset got %b expected 0", Overlong);
        end
        InterPacketDelay = 32'd0;
        for (int f = 0; f < 17; f++) pushFrame(1, 1, 100 + f);
        waitDone(ok);
        checks++;
        if (!ok || FramesSent1 !== 4'd1 || FramesSent0 !== 4'd0) begin
            errors++;
            $display("FAIL wrap got ok=%b fs0=%0d fs1=%0d expected 1 0 1",
                     ok, FramesSent0, FramesSent1);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        applyReset();
        InterPacketDelay = 32'd0;
        pushFrame(1, 1, 49);
        waitBeats(1, ok);
        pushFrame(0, 5, 50);
        waitBeats(3, ok);
        checks++;
        if (!ok || FramesSent1 !== 4'd1) begin
            errors++;
            $display("FAIL mid_pre got ok=%b fs1=%0d expected 1 1", ok, FramesSent1);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        clearAll();
        checks++;
        if (Busy !== 1'b0 || FramesSent0 !== 4'd0 || FramesSent1 !== 4'd0) begin
            errors++;
            $display("FAIL mid_regs got busy=%b fs0=%0d fs1=%0d expected 0 0 0",
                     Busy, FramesSent0, FramesSent1);
        end
        @(negedge clk);
        #2;
        checks++;
        if (MTvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_mvalid got %b expected 0", MTvalid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        pushFrame(1, 1, 60);
        pushFrame(0, 1, 61);
        waitDone(ok);
        checks++;
        if (!ok || startLog.size() != 2 || startLog[0].src != 0) begin
            errors++;
            $display("FAIL mid_tie got ok=%b frames=%0d first=%0d expected 1 2 0",
                     ok, startLog.size(), startLog.size() > 0 ? startLog[0].src : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_overlong();
        test_counter_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rvvitxarb.md
# rvvitxarb

Frame-atomic arbiter and scheduler for the tracer's Ethernet MAC transmit AXI-stream port. It sits between the MAC TX FIFO input and two requesters: source 0, the RVVI trace packetizer, and source 1, a control/status packet generator. It grants the port one whole frame at a time using round-robin. After each frame it enforces a host-programmable inter-packet gap and keeps per-source frame counters and an overlong-frame error flag.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI-stream data width.
- KEEP_WIDTH, DATA_WIDTH/8, byte-strobe width.
- MAX_FRAME_BEATS, 512, beat count above which a frame is flagged overlong.
- CNT_WIDTH, 16, width of the per-source frame counters.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- S0Tdata / S1Tdata  in  DATA_WIDTH  source payload.
- S0Tkeep / S1Tkeep  in  KEEP_WIDTH  source byte strobes.
- S0Tvalid / S1Tvalid  in  1  source beat valid.
- S0Tlast / S1Tlast  in  1  last beat of a source frame.
- S0Tready / S1Tready  out  1  beat accepted from that source.
- MTdata  out  DATA_WIDTH  data to the MAC.
- MTkeep  out  KEEP_WIDTH  byte strobes to the MAC.
- MTvalid  out  1  beat valid to the MAC.
- MTlast  out  1  last beat to the MAC.
- MTready  in  1  MAC accepts the beat.
- InterPacketDelay  in  32  gap in cycles after each frame.
- Grant  out  1  index of the source owning the port; meaningful only when Busy=1.
- Busy  out  1  high in SEND.
- FramesSent0 / FramesSent1  out  CNT_WIDTH  completed frames per source.
- Overlong  out  1  sticky error flag.

## Operation
- The FSM has three states: IDLE, SEND, GAP.
- IDLE:
  - Tready and MTvalid are 0.
  - If either SxTvalid is 1: register Grant and go to SEND.
  - If both sources are valid, grant the one not granted last (~LastGrant). Otherwise grant the single valid source.
  - LastGrant is updated on entry to SEND.
- SEND:
  - MTdata, MTkeep, MTlast and MTvalid mux combinationally from the granted source.
  - The granted source's Tready = MTready. The other source's Tready = 0.
  - Beat handshake = MTvalid & MTready.
  - Each handshake increments BeatCnt (saturating, width clog2(MAX_FRAME_BEATS)+1).
  - If a handshake occurs while BeatCnt == MAX_FRAME_BEATS, set Overlong. The frame is not truncated; it still ends only on Tlast.
  - On a handshake with MTlast=1:
    - increment FramesSent[Grant] (wraps modulo 2^CNT_WIDTH);
    - clear BeatCnt;
    - load GapCnt = InterPacketDelay, sampled on that cycle;
    - go to GAP if InterPacketDelay != 0, otherwise go to IDLE.
- GAP:
  - Tready and MTvalid are 0. GapCnt decrements each cycle.
  - When GapCnt == 1, go to IDLE next cycle.
  - Changes to InterPacketDelay during GAP have no effect on the current gap.
- A source dropping Tvalid mid-frame keeps the grant. MTvalid follows it low, with no preemption or timeout.
- Overlong clears only on reset.

## Timing
- Reset values:
  - state IDLE; Grant 0; LastGrant 1, so source 0 wins the first tie; Busy 0.
  - MTvalid 0, MTlast 0; S0Tready and S1Tready 0.
  - FramesSent0 and FramesSent1 0; Overlong 0; GapCnt 0; BeatCnt 0.
- Arbitration latency: source valid in IDLE at cycle n → first beat presented on M at cycle n+1.
- Gap timing: last-beat handshake at cycle t, with D = InterPacketDelay:
  - GAP covers t+1..t+D; IDLE at t+D+1; the next frame's first beat appears at t+D+2 at earliest.
  - With D=0: IDLE at t+1, next first beat at t+2.
- Data path: zero latency combinational in SEND. There is no buffering, and backpressure passes straight through.
- Counter updates: FramesSent and Overlong update on the clock edge following the qualifying handshake.
- Simultaneous events:
  - Both sources become valid in the same IDLE cycle: round-robin decides.
  - A new request arriving during SEND or GAP waits and does not alter Grant.
- Reset mid-frame: the FSM returns to IDLE the next cycle and the partial frame is abandoned on M (MTvalid 0). Upstream sources are responsible for their own reset.

## Test plan
- Single frame: 4-beat S0 frame, MTready=1, D=3 → M beats at cycles 1–4 with MTlast on beat 4; FramesSent0=1; Busy=0 for cycles 5–8; an S1 frame first appears on M at cycle 9.
- Tie, round-robin: both sources hold continuous 2-beat frames, D=0 → grants alternate 0,1,0,1; after 8 frames FramesSent0=4 and FramesSent1=4; no beat interleaving within a frame.
- Backpressure: MTready toggles 1,0,1,0 during a 3-beat S1 frame → S1Tready equals MTready only while granted; S0Tready stays 0; data order is preserved.
- Overlong: MAX_FRAME_BEATS=8, S0 sends 10 beats → Overlong rises after the 9th handshake; all 10 beats pass; FramesSent0=1; Overlong stays 1 until reset.
- Counter wrap: CNT_WIDTH=4, 17 S1 frames → FramesSent1=1.
- Reset mid-frame: reset asserted after beat 2 of a 5-beat frame → next cycle MTvalid=0, counters 0; the first tie after reset is granted to S0.
